// File: rtl/mem_access_stage_if.sv
// Load/store bus between the EX/MEM pipeline register and the MEM stage.
interface mem_access_stage_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output mem_read, mem_write, addr, wdata, input rdata);
  modport slave  (input mem_read, mem_write, addr, wdata, output rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: word-addressed data RAM plus timer/LED/switch/7-seg peripherals, combinational load data.
// Optional free-running SYSTICK counter at offset 0x18 is built when MEM_SYSTICK_EN is defined.
module mem_access_stage #(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] PERI_BASE = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_stage_if.slave bus,
  input  logic [7:0]        switches,
  output logic [7:0]        leds,
  output logic [11:0]       digi,
  output logic              irq
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  typedef enum logic [2:0] {
    REG_TH      = 3'd0,
    REG_TL      = 3'd1,
    REG_TCON    = 3'd2,
    REG_LED     = 3'd3,
    REG_SWITCH  = 3'd4,
    REG_DIGI    = 3'd5,
    REG_SYSTICK = 3'd6,
    REG_NONE    = 3'd7
  } peri_reg_e;

  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      th;
  logic [31:0]      tl;
  logic [2:0]       tcon;
  logic [31:0]      ram_offset;
  logic             ram_hit;
  logic             peri_hit;
  logic [IDX_W-1:0] ram_idx;
  peri_reg_e        peri_sel;
  logic [31:0]      systick_value;

  // Offset is checked against the full window, so addresses just past the RAM never alias.
  assign ram_offset = bus.addr - RAM_BASE;
  assign ram_hit    = (bus.addr >= RAM_BASE) && (ram_offset < RAM_BYTES);
  assign ram_idx    = ram_offset[IDX_W+1:2];
  assign peri_hit   = (bus.addr[31:5] == PERI_BASE[31:5]);
  assign peri_sel   = peri_reg_e'(bus.addr[4:2]);
  assign irq        = tcon[2];

  // RAM keeps its contents across reset; a store during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && bus.mem_write && ram_hit) begin
      ram[ram_idx] <= bus.wdata;
    end
  end

  // Timer update comes first so a CPU store to the same register overrides it this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      leds <= '0;
      digi <= '0;
    end else begin
      if (tcon[0]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[1]) begin
            tcon[2] <= 1'b1;
          end
        end else begin
          tl <= tl + 32'd1;
        end
      end
      if (bus.mem_write && peri_hit) begin
        case (peri_sel)
          REG_TH:   th   <= bus.wdata;
          REG_TL:   tl   <= bus.wdata;
          REG_TCON: tcon <= bus.wdata[2:0];
          REG_LED:  leds <= bus.wdata[7:0];
          REG_DIGI: digi <= bus.wdata[11:0];
          default:  ;
        endcase
      end
    end
  end

`ifdef MEM_SYSTICK_EN
  logic [31:0] systick;

  always_ff @(posedge clk) begin
    if (reset) begin
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
    end
  end

  assign systick_value = systick;
`else
  assign systick_value = 32'd0;
`endif

  // Reads show the pre-store value even when a store to the same location is in flight.
  always_comb begin
    bus.rdata = '0;
    if (bus.mem_read) begin
      if (ram_hit) begin
        bus.rdata = ram[ram_idx];
      end else if (peri_hit) begin
        case (peri_sel)
          REG_TH:      bus.rdata = th;
          REG_TL:      bus.rdata = tl;
          REG_TCON:    bus.rdata = {29'd0, tcon};
          REG_LED:     bus.rdata = {24'd0, leds};
          REG_SWITCH:  bus.rdata = {24'd0, switches};
          REG_DIGI:    bus.rdata = {20'd0, digi};
          REG_SYSTICK: bus.rdata = systick_value;
          default:     bus.rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage against a behavioural model of RAM, timer and peripherals.
module tb_mem_access_stage;

  localparam logic [31:0] PERI = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  switches;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        irq;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .switches (switches),
    .leds     (leds),
    .digi     (digi),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int cmp_count  = 0;
  int fail_count = 0;

  logic [31:0] ram_m [int];
  logic [31:0] m_th;
  logic [31:0] m_tl;
  logic [31:0] m_tick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_leds;
  logic [11:0] m_digi;

  task automatic model_read(input logic rd, input logic [31:0] a,
                            output logic [31:0] v, output bit known);
    v = '0;
    known = 1'b1;
    if (!rd) return;
    if (a < 32'd1024) begin
      if (ram_m.exists(int'(a >> 2))) v = ram_m[int'(a >> 2)];
      else known = 1'b0;
    end else if (a >= PERI && a < PERI + 32'h20) begin
      case ((a - PERI) >> 2)
        0: v = m_th;
        1: v = m_tl;
        2: v = {29'd0, m_tcon};
        3: v = {24'd0, m_leds};
        4: v = {24'd0, switches};
        5: v = {20'd0, m_digi};
`ifdef MEM_SYSTICK_EN
        6: v = m_tick;
`endif
        default: v = '0;
      endcase
    end
  endtask

  task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (reset) begin
      m_th = '0; m_tl = '0; m_tcon = '0; m_leds = '0; m_digi = '0; m_tick = '0;
      return;
    end
    m_tick = m_tick + 32'd1;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        m_tl = m_th;
        if (m_tcon[1]) m_tcon[2] = 1'b1;
      end else begin
        m_tl = m_tl + 32'd1;
      end
    end
    if (!wr) return;
    if (a < 32'd1024) begin
      ram_m[int'(a >> 2)] = d;
    end else if (a >= PERI && a < PERI + 32'h20) begin
      case ((a - PERI) >> 2)
        0: m_th   = d;
        1: m_tl   = d;
        2: m_tcon = d[2:0];
        3: m_leds = d[7:0];
        5: m_digi = d[11:0];
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive, sample load data before the edge, advance the model at the edge.
  task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] got, output logic [31:0] exp, output bit known);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
    #1;
    got = bus.rdata;
    model_read(rd, a, exp, known);
    @(posedge clk);
    model_step(wr, a, d);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    bit known;
    reset = 1'b1;
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, got, exp, known);
    reset = 1'b0;
    cmp_count++;
    if (leds !== 8'h00) begin fail_count++; $display("[TB] FAIL reset_leds: got %h, expected 00", leds); end
    cmp_count++;
    if (digi !== 12'h000) begin fail_count++; $display("[TB] FAIL reset_digi: got %h, expected 000", digi); end
    cmp_count++;
    if (irq !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_irq: got %b, expected 0", irq); end
    for (int i = 0; i < 3; i++) begin
      bus_cycle(1'b1, 1'b0, PERI + 32'(4 * i), 32'h0, got, exp, known);
      cmp_count++;
      if (got !== 32'h0) begin
        fail_count++;
        $display("[TB] FAIL reset_reg%0d: got %h, expected 00000000", i, got);
      end
    end
  endtask

  task automatic test_ram();
    logic [31:0] got, exp;
    bit known;
    bus_cycle(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, got, exp, known);
    bus_cycle(1'b1, 1'b0, 32'h13, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'hDEAD_BEEF) begin fail_count++; $display("[TB] FAIL ram_load_low_bits: got %h, expected deadbeef", got); end
    bus_cycle(1'b1, 1'b1, 32'h10, 32'h1234_5678, got, exp, known);
    cmp_count++;
    if (got !== 32'hDEAD_BEEF) begin fail_count++; $display("[TB] FAIL ram_rw_prewrite: got %h, expected deadbeef", got); end
    bus_cycle(1'b1, 1'b0, 32'h10, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h1234_5678) begin fail_count++; $display("[TB] FAIL ram_rw_commit: got %h, expected 12345678", got); end
    bus_cycle(1'b0, 1'b0, 32'h10, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h0) begin fail_count++; $display("[TB] FAIL ram_no_read: got %h, expected 00000000", got); end
  endtask

  task automatic test_ram_miss();
    logic [31:0] got, exp;
    bit known;
    bus_cycle(1'b0, 1'b1, 32'h0, 32'hCAFE_0001, got, exp, known);
    bus_cycle(1'b0, 1'b1, 32'h3FC, 32'h5A5A_0FF0, got, exp, known);
    bus_cycle(1'b1, 1'b0, 32'h400, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h0) begin fail_count++; $display("[TB] FAIL ram_miss_load: got %h, expected 00000000", got); end
    bus_cycle(1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, got, exp, known);
    bus_cycle(1'b1, 1'b0, 32'h0, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'hCAFE_0001) begin fail_count++; $display("[TB] FAIL ram_miss_store: got %h, expected cafe0001", got); end
    bus_cycle(1'b1, 1'b0, 32'h3FE, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h5A5A_0FF0) begin fail_count++; $display("[TB] FAIL ram_top_word: got %h, expected 5a5a0ff0", got); end
  endtask

  task automatic test_peripherals();
    logic [31:0] got, exp;
    bit known;
    switches = 8'hA5;
    bus_cycle(1'b1, 1'b0, PERI + 32'h10, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h0000_00A5) begin fail_count++; $display("[TB] FAIL switch_load: got %h, expected 000000a5", got); end
    bus_cycle(1'b0, 1'b1, PERI + 32'h10, 32'h0000_0011, got, exp, known);
    bus_cycle(1'b0, 1'b1, PERI + 32'h0C, 32'hFFFF_FF3C, got, exp, known);
    cmp_count++;
    if (leds !== 8'h3C) begin fail_count++; $display("[TB] FAIL led_store: got %h, expected 3c", leds); end
    bus_cycle(1'b1, 1'b1, PERI + 32'h14, 32'hFFFF_FABC, got, exp, known);
    cmp_count++;
    if (digi !== 12'hABC) begin fail_count++; $display("[TB] FAIL digi_store: got %h, expected abc", digi); end
    bus_cycle(1'b1, 1'b0, PERI + 32'h14, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h0000_0ABC) begin fail_count++; $display("[TB] FAIL digi_load: got %h, expected 00000abc", got); end
    bus_cycle(1'b1, 1'b0, PERI + 32'h11, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h0000_00A5) begin fail_count++; $display("[TB] FAIL switch_ro: got %h, expected 000000a5", got); end
    bus_cycle(1'b1, 1'b0, PERI + 32'h1C, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h0) begin fail_count++; $display("[TB] FAIL peri_unused: got %h, expected 00000000", got); end
  endtask

  task automatic test_timer_overflow();
    logic [31:0] got, exp;
    bit known;
    bus_cycle(1'b0, 1'b1, PERI + 32'h00, 32'hFFFF_FFFC, got, exp, known);
    bus_cycle(1'b0, 1'b1, PERI + 32'h04, 32'hFFFF_FFFE, got, exp, known);
    bus_cycle(1'b0, 1'b1, PERI + 32'h08, 32'h0000_0003, got, exp, known);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, got, exp, known);
    cmp_count++;
    if (irq !== 1'b0) begin fail_count++; $display("[TB] FAIL irq_early: got %b, expected 0", irq); end
    bus_cycle(1'b1, 1'b0, PERI + 32'h04, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'hFFFF_FFFF) begin fail_count++; $display("[TB] FAIL tl_before_wrap: got %h, expected ffffffff", got); end
    cmp_count++;
    if (irq !== 1'b1) begin fail_count++; $display("[TB] FAIL irq_set: got %b, expected 1", irq); end
    bus_cycle(1'b1, 1'b0, PERI + 32'h04, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'hFFFF_FFFC) begin fail_count++; $display("[TB] FAIL tl_reload: got %h, expected fffffffc", got); end
  endtask

  task automatic test_irq_clear();
    logic [31:0] got, exp;
    bit known;
    bus_cycle(1'b1, 1'b1, PERI + 32'h08, 32'h0000_0003, got, exp, known);
    cmp_count++;
    if (got !== 32'h0000_0007) begin fail_count++; $display("[TB] FAIL tcon_prewrite: got %h, expected 00000007", got); end
    cmp_count++;
    if (irq !== 1'b0) begin fail_count++; $display("[TB] FAIL irq_clear: got %b, expected 0", irq); end
    bus_cycle(1'b1, 1'b0, PERI + 32'h04, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== exp) begin fail_count++; $display("[TB] FAIL tl_after_clear: got %h, expected %h", got, exp); end
  endtask

  task automatic test_store_overflow();
    logic [31:0] got, exp;
    bit known;
    bus_cycle(1'b0, 1'b1, PERI + 32'h04, 32'hFFFF_FFFF, got, exp, known);
    bus_cycle(1'b0, 1'b1, PERI + 32'h04, 32'h0000_1234, got, exp, known);
    cmp_count++;
    if (irq !== m_tcon[2]) begin fail_count++; $display("[TB] FAIL irq_tl_store: got %b, expected %b", irq, m_tcon[2]); end
    bus_cycle(1'b1, 1'b0, PERI + 32'h04, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h0000_1234) begin fail_count++; $display("[TB] FAIL tl_store_wins: got %h, expected 00001234", got); end
    bus_cycle(1'b0, 1'b1, PERI + 32'h04, 32'hFFFF_FFFF, got, exp, known);
    bus_cycle(1'b0, 1'b1, PERI + 32'h08, 32'h0000_0003, got, exp, known);
    cmp_count++;
    if (irq !== 1'b0) begin fail_count++; $display("[TB] FAIL tcon_store_wins: got %b, expected 0", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    bit known;
    bus_cycle(1'b0, 1'b1, PERI + 32'h0C, 32'h0000_0077, got, exp, known);
    bus_cycle(1'b0, 1'b1, PERI + 32'h14, 32'h0000_0123, got, exp, known);
    reset = 1'b1;
    bus_cycle(1'b0, 1'b1, PERI + 32'h0C, 32'h0000_00FF, got, exp, known);
    reset = 1'b0;
    cmp_count++;
    if (leds !== 8'h00 || digi !== 12'h000 || irq !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_mid_outputs: got leds=%h digi=%h irq=%b, expected 00 000 0", leds, digi, irq);
    end
    bus_cycle(1'b1, 1'b0, PERI + 32'h04, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_mid_tl: got %h, expected 00000000", got); end
    bus_cycle(1'b1, 1'b0, PERI + 32'h08, 32'h0, got, exp, known);
    cmp_count++;
    if (got !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_mid_tcon: got %h, expected 00000000", got); end
    for (int i = 0; i < 8; i++) bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, got, exp, known);
    bus_cycle(1'b1, 1'b0, PERI + 32'h18, 32'h0, got, exp, known);
`ifdef MEM_SYSTICK_EN
    cmp_count++;
    if (got !== 32'd10) begin fail_count++; $display("[TB] FAIL systick: got %0d, expected 10", got); end
`else
    cmp_count++;
    if (got !== 32'd0) begin fail_count++; $display("[TB] FAIL systick_absent: got %h, expected 00000000", got); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] got, exp, a, d;
    logic        rd, wr;
    bit          known;
    int unsigned sel;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) a = {22'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'd0} >> 2;
      else if (sel == 4) a = 32'h3E0 + 32'($urandom_range(0, 31));
      else if (sel == 5) a = (sel[0] ? 32'h400 : 32'h8000_0000) + ($urandom & 32'h0000_FFFF);
      else a = PERI + 32'($urandom_range(0, 31));
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 2) == 0);
      d  = $urandom;
      switches = 8'($urandom);
      bus_cycle(rd, wr, a, d, got, exp, known);
      if (known) begin
        cmp_count++;
        if (got !== exp) begin fail_count++; $display("[TB] FAIL rand_rdata@%h: got %h, expected %h", a, got, exp); end
      end
      cmp_count++;
      if (leds !== m_leds || digi !== m_digi || irq !== m_tcon[2]) begin
        fail_count++;
        $display("[TB] FAIL rand_outputs: got leds=%h digi=%h irq=%b, expected %h %h %b",
                 leds, digi, irq, m_leds, m_digi, m_tcon[2]);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    switches      = 8'h00;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_ram();
    test_ram_miss();
    test_peripherals();
    test_timer_overflow();
    test_irq_clear();
    test_store_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
